// File: rtl/distance_filter.sv
// Range-checked 4-sample moving average with hysteretic obstacle flag and stale detection.
// Averaged result and flags appear 2 clocks after an accepted sample; accepts one sample per clock.
module distance_filter #(
  parameter int DATA_W       = 8,
  parameter int AVG_LOG2     = 2,
  parameter int MIN_VALID    = 2,
  parameter int MAX_VALID    = 200,
  parameter int NEAR_THRESH  = 20,
  parameter int FAR_THRESH   = 30,
  parameter int STALE_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg_distance,
  output logic              avg_valid,
  output logic              avg_strobe,
  output logic              obstacle,
  output logic              stale,
  output logic [7:0]        reject_count
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int TMR_W  = $clog2(STALE_CYCLES + 1);
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALE = 2'd2;

  localparam logic [DATA_W-1:0] MIN_V   = DATA_W'(MIN_VALID);
  localparam logic [DATA_W-1:0] MAX_V   = DATA_W'(MAX_VALID);
  localparam logic [DATA_W-1:0] NEAR_V  = DATA_W'(NEAR_THRESH);
  localparam logic [DATA_W-1:0] FAR_V   = DATA_W'(FAR_THRESH);
  localparam logic [TMR_W-1:0]  STALE_V = TMR_W'(STALE_CYCLES);
  localparam logic [FILL_W-1:0] DEPTH_V = FILL_W'(DEPTH);

  logic [DATA_W-1:0]   ring_q [DEPTH];
  logic [DATA_W-1:0]   ring_d [DEPTH];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          state_q, state_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                vld_q, vld_d;
  logic                strobe_q, strobe_d;
  logic                obs_q, obs_d;
  logic                stale_q, stale_d;
  logic [7:0]          rej_q, rej_d;

  logic                accept;
  logic [TMR_W-1:0]    timer_inc;
  logic [DATA_W-1:0]   avg_new;

  assign accept    = sample_valid && (sample >= MIN_V) && (sample <= MAX_V);
  assign timer_inc = (timer_q == STALE_V) ? timer_q : timer_q + 1'b1;
  assign avg_new   = sum_q[SUM_W-1:AVG_LOG2];

  always_comb begin
    ring_d   = ring_q;
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    timer_d  = timer_q;
    state_d  = state_q;
    pend_d   = 1'b0;
    avg_d    = avg_q;
    vld_d    = vld_q;
    strobe_d = pend_q;
    obs_d    = obs_q;
    stale_d  = stale_q;
    rej_d    = rej_q;

    // Second pipeline stage: publish the sum captured on the previous edge.
    if (pend_q) begin
      avg_d = avg_new;
      if (state_q == S_RUN) begin
        vld_d = 1'b1;
        if (avg_new < NEAR_V) begin
          obs_d = 1'b1;
        end else if (avg_new >= FAR_V) begin
          obs_d = 1'b0;
        end
      end else begin
        vld_d = 1'b0;
        obs_d = 1'b0;
      end
    end

    if (accept) begin
      ring_d[ptr_q] = sample;
      sum_d         = sum_q + SUM_W'(sample) - SUM_W'(ring_q[ptr_q]);
      ptr_d         = ptr_q + 1'b1;
      timer_d       = '0;
      pend_d        = 1'b1;
      stale_d       = 1'b0;
      case (state_q)
        S_STALE: begin
          fill_d  = FILL_W'(1);
          state_d = S_FILL;
        end
        S_FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_q + 1'b1 == DEPTH_V) begin
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end else begin
      timer_d = timer_inc;
      if (sample_valid && (rej_q != 8'hFF)) begin
        rej_d = rej_q + 1'b1;
      end
      // Flushing the window lets partial sums stay exact when refilling.
      if ((state_q != S_STALE) && (timer_inc == STALE_V)) begin
        state_d = S_STALE;
        for (int i = 0; i < DEPTH; i++) begin
          ring_d[i] = '0;
        end
        sum_d   = '0;
        fill_d  = '0;
        ptr_d   = '0;
        stale_d = 1'b1;
        vld_d   = 1'b0;
        obs_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      sum_q    <= '0;
      ptr_q    <= '0;
      fill_q   <= '0;
      timer_q  <= '0;
      state_q  <= S_FILL;
      pend_q   <= 1'b0;
      avg_q    <= '0;
      vld_q    <= 1'b0;
      strobe_q <= 1'b0;
      obs_q    <= 1'b0;
      stale_q  <= 1'b0;
      rej_q    <= '0;
    end else begin
      ring_q   <= ring_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      avg_q    <= avg_d;
      vld_q    <= vld_d;
      strobe_q <= strobe_d;
      obs_q    <= obs_d;
      stale_q  <= stale_d;
      rej_q    <= rej_d;
    end
  end

  assign avg_distance = avg_q;
  assign avg_valid    = vld_q;
  assign avg_strobe   = strobe_q;
  assign obstacle     = obs_q;
  assign stale        = stale_q;
  assign reject_count = rej_q;

endmodule

// File: tb/tb_distance_filter.sv
// Directed and random stimulus against a window/queue reference model of the distance filter.
module tb_distance_filter;

  localparam int STALE = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic [7:0] avg_distance;
  logic       avg_valid;
  logic       avg_strobe;
  logic       obstacle;
  logic       stale;
  logic [7:0] reject_count;

  always #10 clk = ~clk;

  distance_filter #(.STALE_CYCLES(STALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .avg_distance (avg_distance),
    .avg_valid    (avg_valid),
    .avg_strobe   (avg_strobe),
    .obstacle     (obstacle),
    .stale        (stale),
    .reject_count (reject_count)
  );

  typedef struct {
    int due;
    int avg;
    bit vld;
    bit obs;
  } ev_t;

  ev_t evq[$];
  int  win[$];
  int  cyc = 0;
  int  idle = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  stale_m = 1'b0;
  bit  obs_m = 1'b0;
  int  exp_avg = 0;
  int  exp_rej = 0;
  bit  exp_vld = 1'b0;
  bit  exp_obs = 1'b0;
  bit  exp_stale = 1'b0;
  bit  exp_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("avg_strobe",   avg_strobe,   exp_strobe);
    chk("avg_distance", avg_distance, exp_avg);
    chk("avg_valid",    avg_valid,    exp_vld);
    chk("obstacle",     obstacle,     exp_obs);
    chk("stale",        stale,        exp_stale);
    chk("reject_count", reject_count, exp_rej);
  endtask

  // One clock: drive inputs, advance the model, then check every output.
  task automatic tick(input bit r, input bit v, input int s);
    bit  acc;
    int  sum;
    int  a;
    bit  full;
    ev_t ev;
    rst = r;
    sample_valid = v;
    sample = 8'(s);
    if (r) begin
      evq.delete();
      win.delete();
      idle = 0;
      stale_m = 0;
      obs_m = 0;
      exp_avg = 0;
      exp_rej = 0;
      exp_vld = 0;
      exp_obs = 0;
      exp_stale = 0;
    end else begin
      acc = v && (s >= 2) && (s <= 200);
      if (acc) begin
        if (stale_m) begin
          stale_m = 0;
          exp_stale = 0;
        end
        if (win.size() == 4) void'(win.pop_front());
        win.push_back(s);
        sum = 0;
        foreach (win[i]) sum += win[i];
        a = sum / 4;
        full = (win.size() == 4);
        if (!full) obs_m = 0;
        else if (a < 20) obs_m = 1;
        else if (a >= 30) obs_m = 0;
        evq.push_back('{due: cyc + 2, avg: a, vld: full, obs: obs_m});
        idle = 0;
      end else begin
        if (v && exp_rej < 255) exp_rej++;
        idle++;
        if (!stale_m && idle == STALE) begin
          stale_m = 1;
          exp_stale = 1;
          exp_vld = 0;
          exp_obs = 0;
          obs_m = 0;
          win.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_strobe = 0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      ev = evq.pop_front();
      exp_strobe = 1;
      exp_avg = ev.avg;
      exp_vld = ev.vld;
      exp_obs = ev.obs;
    end
    check_all();
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick(0, 0, 0);
  endtask

  task automatic feed(input int s);
    tick(0, 1, s);
    idle_n(2);
  endtask

  initial begin
    // Reset and fill with 40s.
    tick(1, 0, 0);
    tick(1, 0, 0);
    repeat (4) feed(40);
    chk("fill_avg_40", avg_distance, 40);

    // Falling then rising distance exercises the hysteresis band.
    repeat (4) feed(10);
    chk("near_obstacle", obstacle, 1);
    repeat (4) feed(35);
    chk("far_clear", obstacle, 0);

    // Out-of-range readings interleaved with valid 50s.
    feed(50); tick(0, 1, 0);
    feed(50); tick(0, 1, 1);
    feed(50); tick(0, 1, 201);
    feed(50); tick(0, 1, 255);
    idle_n(2);
    chk("reject_four", reject_count, 4);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) tick(0, 1, $urandom_range(0, 1));
      else tick(0, 1, $urandom_range(201, 255));
      if (i % 50 == 49) feed(50);
    end
    chk("reject_sat", reject_count, 255);

    // Go stale with obstacle set, then recover with one sample.
    repeat (4) feed(10);
    idle_n(105);
    chk("stale_set", stale, 1);
    feed(60);
    chk("stale_recover_avg", avg_distance, 15);

    // Sample lands exactly when the timer would expire.
    feed(40);
    feed(40);
    feed(40);
    tick(0, 1, 40);
    idle_n(99);
    tick(0, 1, 40);
    idle_n(3);
    chk("stale_race", stale, 0);

    // Back-to-back throughput.
    repeat (8) tick(0, 1, 100);
    tick(0, 1, 20);
    idle_n(2);
    chk("b2b_avg", avg_distance, 80);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 255));
    end
    idle_n(3);

    // Reset one cycle after a sample strobe.
    tick(0, 1, 50);
    tick(1, 0, 0);
    chk("rst_no_strobe", avg_strobe, 0);
    idle_n(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
- Sits directly downstream of the ultrasonic sensor driver.
- Consumes each raw distance reading (valid strobe + 8-bit value) and rejects out-of-range readings.
- Produces a 4-sample moving average, a hysteretic obstacle flag and a stale-data flag.
- Its outputs feed LED display and motion-control logic in place of the raw reading.

Parameters:
- DATA_W, 8, width of distance samples and averaged output.
- AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples).
- MIN_VALID, 2, smallest accepted reading; readings below it are rejected.
- MAX_VALID, 200, largest accepted reading; readings above it are rejected.
- NEAR_THRESH, 20, obstacle asserts when average < NEAR_THRESH.
- FAR_THRESH, 30, obstacle deasserts when average >= FAR_THRESH; FAR_THRESH > NEAR_THRESH.
- STALE_CYCLES, 50_000_000, clocks without an accepted sample before data is declared stale (1 s at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- sample_valid  in  1  single-cycle strobe; sample is meaningful only in this cycle.
- sample  in  DATA_W  raw distance reading from the sensor driver.
- avg_distance  out  DATA_W  moving-average distance.
- avg_valid  out  1  high while the window holds 2^AVG_LOG2 accepted samples and data is not stale.
- avg_strobe  out  1  one-cycle pulse each time avg_distance updates.
- obstacle  out  1  hysteretic near-obstacle flag.
- stale  out  1  no accepted sample for STALE_CYCLES clocks.
- reject_count  out  8  saturating count of rejected samples.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All outputs go to 0, state FILL, ring buffer cleared to 0, running sum 0, fill count 0, stale timer 0.
  - Reset mid-operation discards the in-flight sample, and avg_strobe does not fire for it.
- Acceptance:
  - A sample is accepted when sample_valid=1 and MIN_VALID <= sample <= MAX_VALID.
  - Otherwise, if sample_valid=1, it is rejected: reject_count increments and saturates at 255.
  - Rejected samples do not touch the buffer, sum or stale timer.
- Pipeline, for sample_valid high in cycle t:
  - Edge ending t: buffer[wr_ptr] <= sample; sum <= sum + sample - buffer[wr_ptr]; wr_ptr increments mod 2^AVG_LOG2.
  - Edge ending t+1: avg_distance <= sum >> AVG_LOG2 (truncating); obstacle updated; avg_strobe high during t+2.
  - Latency is 2 clocks. Back-to-back samples every cycle are supported at throughput 1/cycle.
- Sum width is DATA_W+AVG_LOG2 bits and cannot overflow. Buffer slots are zero before fill, so partial sums are exact.
- States:
  - FILL:
    - Accepted samples increment the fill count; avg_strobe fires and avg_distance updates, but avg_valid=0.
    - obstacle is held at 0.
    - When fill count reaches 2^AVG_LOG2, go to RUN, with avg_valid=1 in the same cycle as that sample's avg_strobe.
  - RUN:
    - avg_valid=1.
    - On each update: obstacle <= 1 if new average < NEAR_THRESH; obstacle <= 0 if new average >= FAR_THRESH; otherwise obstacle holds.
  - STALE:
    - Entered from FILL or RUN when the stale timer reaches STALE_CYCLES.
    - In the entry cycle: stale=1, avg_valid=0, obstacle=0, buffer/sum/fill count/wr_ptr flushed to 0. avg_distance holds its last value.
    - The next accepted sample clears stale and moves to FILL with fill count 1.
- Stale timer:
  - Cleared on every accepted sample; otherwise increments, saturating at STALE_CYCLES.
  - If an accepted sample arrives in the same cycle the timer would reach STALE_CYCLES, the sample wins: no STALE entry.
- Rejected and accepted events are mutually exclusive per cycle. sample is ignored when sample_valid=0.

Test Plan (bench uses STALE_CYCLES=100; other parameters at default):
- Reset, then accepted samples 40,40,40,40 on consecutive strobes -> avg_strobe after each at +2 clocks; avg_distance 10,20,30,40; avg_valid rises with the 4th update; obstacle=0; stale=0.
- From RUN at 40, feed 10,10,10,10 -> averages 32,25,17,10; obstacle rises at the 17 update. Then feed 35,35,35,35 -> averages 16,22,28,35; obstacle clears only at the 35 update, so it holds through 22 and 28.
- Feed 0, 1, 201, 255 interleaved with valid 50s -> reject_count=4; averages computed from the 50s only; stale timer not cleared by rejects. Then 300 rejects -> reject_count saturates at 255.
- No accepted sample for 100 clocks after RUN with obstacle=1 -> stale=1, avg_valid=0, obstacle=0. Next accepted sample 60 -> stale=0, FILL, avg_distance=15 with avg_valid=0.
- Accepted sample exactly in the cycle the timer would hit 100 -> stale stays 0.
- Eight back-to-back accepted samples 100,100,...,100, then 20 -> eight consecutive avg_strobe pulses, then 80 on the strobe for the 20.
- Assert rst one cycle after a sample_valid -> no avg_strobe; all outputs 0 the following cycle.
